gear_led_decoder: RTL and testbench
===================================

GEAR_LED_DECODER -- requirements
Module: gear_led_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive synchronized cycles a pattern must hold before acceptance (legal range 2..15).
REQ-002 SHALL have port clk  input  1  single clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port led_in  input  7  segment pattern {g,f,e,d,c,b,a}, active high.
REQ-005 SHALL have port gear_code  output  2  accepted gear: P=0, R=1, N=2, D=3.
REQ-006 SHALL have port gear_valid  output  1  high while an accepted legal gear is held.
REQ-007 SHALL have port gear_strobe  output  1  one-cycle pulse on each accepted gear change.
REQ-008 SHALL have port illegal_pat  output  1  sticky flag: a stable pattern is not P/R/N/D/blank.
REQ-009 SHALL have port illegal_trans  output  1  sticky flag: an accepted gear change skipped a position.
REQ-010 SHALL have port change_cnt  output  8  count of accepted legal gear changes.

Function
REQ-011 SHALL pass led_in through a 2-flop synchronizer before any use.
REQ-012 SHALL decode only these patterns: P=7'h73, R=7'h50, N=7'h54, D=7'h5E, blank=7'h00; every other value is illegal.
REQ-013 SHALL hold a candidate register and a 4-bit stability counter; the counter resets to 0 when the synchronized pattern differs from the candidate, otherwise increments, saturating at STABLE_CYCLES.
REQ-014 SHALL accept the candidate in the cycle its counter first reaches STABLE_CYCLES, so a new pattern is acted on 2+STABLE_CYCLES cycles after it appears on led_in.
REQ-015 SHALL implement FSM states NO_GEAR, LOCKED and FAULT; NO_GEAR is entered from reset.
REQ-016 NO_GEAR: an accepted legal gear sets gear_code, raises gear_valid, pulses gear_strobe and enters LOCKED; change_cnt is not incremented.
REQ-017 LOCKED: an accepted gear adjacent in order P-R-N-D updates gear_code, pulses gear_strobe and increments change_cnt.
REQ-018 LOCKED: an accepted gear equal to gear_code produces no strobe and no count.
REQ-019 LOCKED: an accepted non-adjacent gear (for example P->N or P->D) sets illegal_trans, updates gear_code, pulses gear_strobe, does not increment change_cnt, and stays LOCKED.
REQ-020 Any state: an accepted blank drops gear_valid and enters NO_GEAR; gear_code holds its last value.
REQ-021 Any state: an accepted illegal pattern sets illegal_pat, drops gear_valid and enters FAULT.
REQ-022 FAULT: only an accepted blank exits, to NO_GEAR; legal gears are ignored.
REQ-023 change_cnt SHALL wrap from 255 to 0.
REQ-024 illegal_pat and illegal_trans SHALL clear only on reset.
REQ-025 A pattern that changes before reaching STABLE_CYCLES SHALL have no effect on any output.

Reset
REQ-026 While rst_n is low: FSM=NO_GEAR, gear_code=0, gear_valid=0, gear_strobe=0, illegal_pat=0, illegal_trans=0, change_cnt=0, synchronizer=0, candidate=7'h00, counter=0.
REQ-027 Reset asserted mid-acceptance SHALL discard the candidate; after release a pattern needs the full 2+STABLE_CYCLES again.

Structure
REQ-028 SHALL put the gear code constants, the segment pattern constants and the FSM state encoding in a shared package gear_pkg.
REQ-029 SHALL implement the synchronizer and stability counter as sub-module led_stable_filter, which outputs a stable pattern and a one-cycle accept pulse.

Verification
REQ-030 Reset, hold led_in=7'h73 -> strobe at cycle 6 after release, gear_code=0, gear_valid=1, change_cnt=0.
REQ-031 P then R then N then D, each held 10 cycles -> 4 strobes total, final gear_code=3, change_cnt=3, both flags 0.
REQ-032 LOCKED in P, apply 7'h5E -> gear_code=3, illegal_trans=1, change_cnt unchanged.
REQ-033 In R, glitch to 7'h54 for 3 cycles then back to 7'h50 -> no strobe, gear_code=1 unchanged.
REQ-034 Apply 7'h7F stable -> illegal_pat=1, gear_valid=0; then 7'h73 -> ignored; then 7'h00 then 7'h73 -> gear_valid=1.
REQ-035 Cycle N<->D 256 legal changes -> change_cnt wraps to 0; assert rst_n low mid-count -> all outputs at reset values immediately.

Source files
------------

// File: rtl/gear_pkg.sv
// -----------------------------------------------------------------------------
// gear_pkg
// Shared definitions for the gear indicator decoder. It holds:
//   - gear codes (P/R/N/D) as they appear on gear_code,
//   - the seven-segment patterns {g,f,e,d,c,b,a} the decoder recognises,
//   - the controller FSM state encoding,
//   - a pattern classifier and a gear adjacency helper.
// -----------------------------------------------------------------------------
package gear_pkg;

  localparam int unsigned LED_W = 7;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    GEAR_P = 2'd0,
    GEAR_R = 2'd1,
    GEAR_N = 2'd2,
    GEAR_D = 2'd3
  } gear_e;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active high.
  localparam logic [LED_W-1:0] PAT_P     = 7'h73;
  localparam logic [LED_W-1:0] PAT_R     = 7'h50;
  localparam logic [LED_W-1:0] PAT_N     = 7'h54;
  localparam logic [LED_W-1:0] PAT_D     = 7'h5E;
  localparam logic [LED_W-1:0] PAT_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_NO_GEAR = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_FAULT   = 2'd2
  } gear_state_e;

  typedef enum logic [1:0] {
    KIND_GEAR    = 2'd0,
    KIND_BLANK   = 2'd1,
    KIND_ILLEGAL = 2'd2
  } pat_kind_e;

  typedef struct packed {
    pat_kind_e kind;
    gear_e     gear;   // meaningful only when kind == KIND_GEAR
  } pat_info_t;

  // Classify a segment pattern. Anything that is not an exact match is
  // illegal; partially lit digits are not forgiven.
  function automatic pat_info_t decode_pattern(input logic [LED_W-1:0] pat);
    pat_info_t info;
    info.kind = KIND_ILLEGAL;
    info.gear = GEAR_P;
    case (pat)
      PAT_P: begin
        info.kind = KIND_GEAR;
        info.gear = GEAR_P;
      end
      PAT_R: begin
        info.kind = KIND_GEAR;
        info.gear = GEAR_R;
      end
      PAT_N: begin
        info.kind = KIND_GEAR;
        info.gear = GEAR_N;
      end
      PAT_D: begin
        info.kind = KIND_GEAR;
        info.gear = GEAR_D;
      end
      PAT_BLANK: info.kind = KIND_BLANK;
      default:   info.kind = KIND_ILLEGAL;
    endcase
    return info;
  endfunction

  // True when two gears are neighbours in the lever order P-R-N-D.
  // Widened to 3 bits so P and D (0 and 3) do not look adjacent by wrap.
  function automatic logic gears_adjacent(input gear_e a, input gear_e b);
    logic [2:0] ua;
    logic [2:0] ub;
    ua = {1'b0, a};
    ub = {1'b0, b};
    return (ua == ub + 3'd1) || (ub == ua + 3'd1);
  endfunction

endpackage

// File: rtl/led_stable_filter.sv
// -----------------------------------------------------------------------------
// led_stable_filter
// Brings the asynchronous segment bus into the clk domain and qualifies it:
// a pattern is handed on only once it has held steady long enough.
//
// Parameters
//   STABLE_CYCLES  consecutive synchronized cycles a pattern must hold
//                  before acceptance (legal range 2..15)
// Ports
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   led_in      in   raw segment pattern {g,f,e,d,c,b,a}
//   stable_pat  out  synchronized pattern (valid to use when accept is high)
//   accept      out  one-cycle pulse, high in the cycle the candidate's
//                    stability count first reaches STABLE_CYCLES
// -----------------------------------------------------------------------------
module led_stable_filter
  import gear_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] led_in,
  output logic [LED_W-1:0] stable_pat,
  output logic             accept
);

  localparam logic [3:0] CNT_MAX    = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_ACCEPT = 4'(STABLE_CYCLES - 1);

  logic [LED_W-1:0] sync_meta;  // first synchronizer stage
  logic [LED_W-1:0] sync_pat;   // second stage: the synchronized pattern
  logic [LED_W-1:0] cand;       // pattern currently being timed
  logic [3:0]       stable_cnt; // cycles the candidate has held, saturating
  logic             cand_match;

  // The candidate follows the value entering the second synchronizer stage,
  // so its stability count advances in step with that stage instead of one
  // cycle behind it. This keeps the total latency at 2 + STABLE_CYCLES.
  assign cand_match = (sync_meta == cand);

  // NOTE: every register here updates with <= so all of them sample the
  // values from before the clock edge; a blocking = would let sync_pat see
  // this cycle's sync_meta and collapse the two synchronizer stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta  <= '0;
      sync_pat   <= '0;
      cand       <= PAT_BLANK;
      stable_cnt <= '0;
    end else begin
      sync_meta <= led_in;
      sync_pat  <= sync_meta;
      if (!cand_match) begin
        cand       <= sync_meta;
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 4'd1;
      end
    end
  end

  // The count reaches CNT_MAX on the coming edge exactly once per run of a
  // pattern; after that it saturates, so accept cannot repeat.
  assign accept     = cand_match && (stable_cnt == CNT_ACCEPT);
  assign stable_pat = sync_pat;

endmodule

// File: rtl/gear_led_decoder.sv
// -----------------------------------------------------------------------------
// gear_led_decoder
// Watches the seven-segment gear indicator of a shifter and turns it into a
// debounced gear code, with change counting and sticky fault flags.
//
// Parameters
//   STABLE_CYCLES  consecutive synchronized cycles a pattern must hold
//                  before acceptance (legal range 2..15)
// Ports
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   led_in [6:0]   in   segment pattern {g,f,e,d,c,b,a}, active high
//   gear_code[1:0] out  accepted gear: P=0, R=1, N=2, D=3 (held over blank)
//   gear_valid     out  high while an accepted legal gear is held
//   gear_strobe    out  one-cycle pulse on each accepted gear change
//   illegal_pat    out  sticky: an accepted pattern was not P/R/N/D/blank
//   illegal_trans  out  sticky: an accepted gear change skipped a position
//   change_cnt[7:0] out count of adjacent gear changes, wraps 255 -> 0
// -----------------------------------------------------------------------------
module gear_led_decoder
  import gear_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] led_in,
  output logic [1:0]       gear_code,
  output logic             gear_valid,
  output logic             gear_strobe,
  output logic             illegal_pat,
  output logic             illegal_trans,
  output logic [CNT_W-1:0] change_cnt
);

  logic [LED_W-1:0] stable_pat;
  logic             accept;
  pat_info_t        info;

  gear_state_e      state_q, state_d;
  gear_e            gear_code_q, gear_code_d;
  logic             gear_valid_q, gear_valid_d;
  logic             gear_strobe_q, gear_strobe_d;
  logic             illegal_pat_q, illegal_pat_d;
  logic             illegal_trans_q, illegal_trans_d;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;

  led_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_in     (led_in),
    .stable_pat (stable_pat),
    .accept     (accept)
  );

  assign info = decode_pattern(stable_pat);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NO_GEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Blank and illegal patterns win from any state; a legal
  // gear only moves the FSM out of NO_GEAR (FAULT ignores it, LOCKED stays).
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb assigns its outputs a default before any branch;
  // a path that leaves one unassigned would infer a latch to hold it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (info.kind)
        KIND_BLANK:   state_d = ST_NO_GEAR;
        KIND_ILLEGAL: state_d = ST_FAULT;
        KIND_GEAR:    if (state_q == ST_NO_GEAR) state_d = ST_LOCKED;
        default:      state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Everything holds
  // unless an accepted pattern says otherwise; the strobe defaults low so it
  // can only ever last one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    gear_code_d     = gear_code_q;
    gear_valid_d    = gear_valid_q;
    gear_strobe_d   = 1'b0;
    illegal_pat_d   = illegal_pat_q;
    illegal_trans_d = illegal_trans_q;
    change_cnt_d    = change_cnt_q;

    if (accept) begin
      case (info.kind)
        KIND_BLANK: begin
          // gear_code keeps the last gear so software can still read it.
          gear_valid_d = 1'b0;
        end
        KIND_ILLEGAL: begin
          illegal_pat_d = 1'b1;
          gear_valid_d  = 1'b0;
        end
        KIND_GEAR: begin
          case (state_q)
            ST_NO_GEAR: begin
              // First gear after blank/reset is a lock-on, not a change.
              gear_code_d   = info.gear;
              gear_valid_d  = 1'b1;
              gear_strobe_d = 1'b1;
            end
            ST_LOCKED: begin
              if (info.gear != gear_code_q) begin
                gear_code_d   = info.gear;
                gear_strobe_d = 1'b1;
                if (gears_adjacent(info.gear, gear_code_q)) begin
                  change_cnt_d = change_cnt_q + 8'd1;
                end else begin
                  illegal_trans_d = 1'b1;
                end
              end
            end
            default: begin
              // FAULT: legal gears are ignored until a blank is seen.
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gear_code_q     <= GEAR_P;
      gear_valid_q    <= 1'b0;
      gear_strobe_q   <= 1'b0;
      illegal_pat_q   <= 1'b0;
      illegal_trans_q <= 1'b0;
      change_cnt_q    <= '0;
    end else begin
      gear_code_q     <= gear_code_d;
      gear_valid_q    <= gear_valid_d;
      gear_strobe_q   <= gear_strobe_d;
      illegal_pat_q   <= illegal_pat_d;
      illegal_trans_q <= illegal_trans_d;
      change_cnt_q    <= change_cnt_d;
    end
  end

  assign gear_code     = gear_code_q;
  assign gear_valid    = gear_valid_q;
  assign gear_strobe   = gear_strobe_q;
  assign illegal_pat   = illegal_pat_q;
  assign illegal_trans = illegal_trans_q;
  assign change_cnt    = change_cnt_q;

endmodule

// File: tb/tb_gear_led_decoder.sv
// -----------------------------------------------------------------------------
// tb_gear_led_decoder
// Directed bench for gear_led_decoder with STABLE_CYCLES = 4. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// A pattern driven after edge k is first sampled at edge k+1 and acted on at
// edge k+6 (two synchronizer stages plus four stable cycles).
// -----------------------------------------------------------------------------
module tb_gear_led_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] led_in;
  logic [1:0] gear_code;
  logic       gear_valid;
  logic       gear_strobe;
  logic       illegal_pat;
  logic       illegal_trans;
  logic [7:0] change_cnt;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  gear_led_decoder #(
    .STABLE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .led_in        (led_in),
    .gear_code     (gear_code),
    .gear_valid    (gear_valid),
    .gear_strobe   (gear_strobe),
    .illegal_pat   (illegal_pat),
    .illegal_trans (illegal_trans),
    .change_cnt    (change_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: wait for the edge, settle, count any strobe seen.
  task automatic step();
    @(posedge clk);
    #1;
    if (gear_strobe === 1'b1) strobes++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_code"},   32'(gear_code),     32'd0);
    check({pfx, "_valid"},  32'(gear_valid),    32'd0);
    check({pfx, "_strobe"}, 32'(gear_strobe),   32'd0);
    check({pfx, "_ipat"},   32'(illegal_pat),   32'd0);
    check({pfx, "_itrans"}, 32'(illegal_trans), 32'd0);
    check({pfx, "_cnt"},    32'(change_cnt),    32'd0);
  endtask

  task automatic do_reset(input logic [6:0] pat, input string pfx);
    led_in = pat;
    rst_n  = 1'b0;
    run(2);
    check_reset_outputs(pfx);
    rst_n   = 1'b1;
    strobes = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    led_in = 7'h00;

    // Reset then hold P: strobe exactly 6 cycles after release.
    do_reset(7'h73, "rst0");
    run(5);
    check("p_early_strobe", 32'(gear_strobe), 32'd0);
    check("p_early_valid",  32'(gear_valid),  32'd0);
    step();
    check("p_strobe",       32'(gear_strobe), 32'd1);
    check("p_code",         32'(gear_code),   32'd0);
    check("p_valid",        32'(gear_valid),  32'd1);
    check("p_cnt",          32'(change_cnt),  32'd0);
    step();
    check("p_strobe_pulse", 32'(gear_strobe), 32'd0);
    check("p_valid_hold",   32'(gear_valid),  32'd1);

    // P -> R -> N -> D, each held 10 cycles.
    do_reset(7'h73, "rst1");
    run(10);
    led_in = 7'h50; run(10);
    led_in = 7'h54; run(10);
    led_in = 7'h5E; run(10);
    check("prnd_strobes", 32'(strobes),       32'd4);
    check("prnd_code",    32'(gear_code),     32'd3);
    check("prnd_cnt",     32'(change_cnt),    32'd3);
    check("prnd_ipat",    32'(illegal_pat),   32'd0);
    check("prnd_itrans",  32'(illegal_trans), 32'd0);
    check("prnd_valid",   32'(gear_valid),    32'd1);

    // P -> D skips two positions.
    do_reset(7'h73, "rst2");
    run(10);
    led_in = 7'h5E; run(10);
    check("skip_code",    32'(gear_code),     32'd3);
    check("skip_itrans",  32'(illegal_trans), 32'd1);
    check("skip_cnt",     32'(change_cnt),    32'd0);
    check("skip_valid",   32'(gear_valid),    32'd1);
    check("skip_strobes", 32'(strobes),       32'd2);
    check("skip_ipat",    32'(illegal_pat),   32'd0);

    // Glitches while in R.
    do_reset(7'h73, "rst3");
    run(10);
    led_in = 7'h50; run(10);
    check("r_code", 32'(gear_code),  32'd1);
    check("r_cnt",  32'(change_cnt), 32'd1);
    strobes = 0;
    led_in = 7'h54; run(3);
    led_in = 7'h50; run(12);
    check("glitch3_strobes", 32'(strobes),    32'd0);
    check("glitch3_code",    32'(gear_code),  32'd1);
    check("glitch3_cnt",     32'(change_cnt), 32'd1);
    // Four samples: the count only reaches 3 before the pattern leaves.
    led_in = 7'h54; run(4);
    led_in = 7'h50; run(12);
    check("glitch4_strobes", 32'(strobes),    32'd0);
    // Five samples: N is accepted, then R again.
    led_in = 7'h54; run(5);
    led_in = 7'h50; run(12);
    check("hold5_strobes", 32'(strobes),    32'd2);
    check("hold5_cnt",     32'(change_cnt), 32'd3);
    check("hold5_code",    32'(gear_code),  32'd1);

    // Illegal pattern, FAULT, exit through blank.
    led_in = 7'h7F; run(10);
    check("ill_ipat",  32'(illegal_pat), 32'd1);
    check("ill_valid", 32'(gear_valid),  32'd0);
    check("ill_code",  32'(gear_code),   32'd1);
    strobes = 0;
    led_in = 7'h73; run(10);
    check("fault_p_valid",   32'(gear_valid), 32'd0);
    check("fault_p_code",    32'(gear_code),  32'd1);
    check("fault_p_strobes", 32'(strobes),    32'd0);
    led_in = 7'h00; run(10);
    check("blank_valid", 32'(gear_valid),  32'd0);
    check("blank_code",  32'(gear_code),   32'd1);
    check("blank_ipat",  32'(illegal_pat), 32'd1);
    led_in = 7'h73; run(10);
    check("relock_valid",   32'(gear_valid),  32'd1);
    check("relock_code",    32'(gear_code),   32'd0);
    check("relock_strobes", 32'(strobes),     32'd1);
    check("relock_ipat",    32'(illegal_pat), 32'd1);
    check("relock_cnt",     32'(change_cnt),  32'd3);

    // N <-> D, 256 changes: counter wraps.
    do_reset(7'h54, "rst4");
    run(10);
    check("nd_start_code",  32'(gear_code),  32'd2);
    check("nd_start_valid", 32'(gear_valid), 32'd1);
    check("nd_start_cnt",   32'(change_cnt), 32'd0);
    for (int i = 0; i < 255; i++) begin
      led_in = (i % 2 == 0) ? 7'h5E : 7'h54;
      run(7);
    end
    check("nd_255_cnt",  32'(change_cnt), 32'd255);
    check("nd_255_code", 32'(gear_code),  32'd3);
    led_in = 7'h54; run(7);
    check("nd_wrap_cnt",    32'(change_cnt),    32'd0);
    check("nd_wrap_code",   32'(gear_code),     32'd2);
    check("nd_wrap_itrans", 32'(illegal_trans), 32'd0);
    led_in = 7'h5E; run(7);
    led_in = 7'h54; run(7);
    check("nd_post_cnt", 32'(change_cnt), 32'd2);

    // Reset mid-acceptance of D: outputs clear without a clock edge.
    led_in = 7'h5E;
    run(3);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("async_rst");
    run(2);
    rst_n   = 1'b1;
    strobes = 0;
    run(5);
    check("rerun_early_strobes", 32'(strobes),    32'd0);
    check("rerun_early_valid",   32'(gear_valid), 32'd0);
    step();
    check("rerun_strobe", 32'(gear_strobe), 32'd1);
    check("rerun_code",   32'(gear_code),   32'd3);
    check("rerun_valid",  32'(gear_valid),  32'd1);
    check("rerun_cnt",    32'(change_cnt),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
